// File: rtl/circuito_exp6_pkg.sv
// Shared definitions for the memory game: FSM state codes, control/status
// bundles between controller and datapath, ROM contents, state decode.
package circuito_exp6_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 3000;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    ESPERA_JOGADA  = 4'h2,
    REGISTRA       = 4'h3,
    COMPARA        = 4'h4,
    PROXIMA_JOGADA = 4'h5,
    PROXIMA_RODADA = 4'h6,
    INICIO_RODADA  = 4'h9,
    FIM_GANHOU     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  // controller -> datapath strobes
  typedef struct packed {
    logic zera_e;    // clear address counter
    logic conta_e;   // increment address counter
    logic zera_l;    // clear limit (round) counter
    logic conta_l;   // increment limit counter
    logic zera_r;    // clear jogada register
    logic registra;  // load botoes into jogada register
    logic zera_t;    // clear timeout counter
    logic conta_t;   // advance timeout counter
  } ctrl_fd_t;

  // datapath -> controller conditions
  typedef struct packed {
    logic jogada;        // one-cycle pulse on rising edge of |botoes
    logic fim_timeout;   // timeout counter at its last count
    logic igual_jogada;  // jogada register == ROM[address]
    logic igual_seq;     // address == limit
    logic fim_rodadas;   // limit == 15 (last round)
  } status_t;

  typedef struct packed {
    ctrl_fd_t fd;
    logic     ganhou;
    logic     perdeu;
    logic     pronto;
    logic     timeout;
  } saida_t;

  function automatic logic [3:0] rom_data(input logic [3:0] a);
    logic [3:0] d;
    case (a)
      4'h0: d = 4'b0001;  4'h1: d = 4'b0010;  4'h2: d = 4'b0100;  4'h3: d = 4'b1000;
      4'h4: d = 4'b0100;  4'h5: d = 4'b0010;  4'h6: d = 4'b0001;  4'h7: d = 4'b0001;
      4'h8: d = 4'b0010;  4'h9: d = 4'b0010;  4'hA: d = 4'b0100;  4'hB: d = 4'b0100;
      4'hC: d = 4'b1000;  4'hD: d = 4'b1000;  4'hE: d = 4'b0001;  default: d = 4'b0100;
    endcase
    return d;
  endfunction

  // Moore decode of a state into datapath strobes and game flags.
  function automatic saida_t decodifica(input estado_t e);
    saida_t s;
    s = '0;
    case (e)
      PREPARA:        begin s.fd.zera_l = 1'b1; s.fd.zera_e = 1'b1; s.fd.zera_r = 1'b1; end
      INICIO_RODADA:  begin s.fd.zera_e = 1'b1; s.fd.zera_t = 1'b1; end
      ESPERA_JOGADA:  s.fd.conta_t = 1'b1;
      REGISTRA:       s.fd.registra = 1'b1;
      PROXIMA_JOGADA: begin s.fd.conta_e = 1'b1; s.fd.zera_t = 1'b1; end
      PROXIMA_RODADA: s.fd.conta_l = 1'b1;
      FIM_GANHOU:     begin s.pronto = 1'b1; s.ganhou = 1'b1; end
      FIM_ERRO:       begin s.pronto = 1'b1; s.perdeu = 1'b1; end
      FIM_TIMEOUT:    begin s.pronto = 1'b1; s.perdeu = 1'b1; s.timeout = 1'b1; end
      default:        s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/circuito_exp6_fd.sv
// Game datapath (fluxo de dados): address/limit counters, jogada register,
// button edge detector, ROM, comparators and the jogada timeout counter.
//  fd            strobes from the controller
//  botoes        player buttons
//  st            conditions to the controller
//  endereco, limite, jogada, memoria  internal values for debug/LEDs
//  fim_seq       address == 15
//  tem_jogada    |botoes
module fluxo_dados_exp6
  import circuito_exp6_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  ctrl_fd_t   fd,
  input  logic [3:0] botoes,
  output status_t    st,
  output logic [3:0] endereco,
  output logic [3:0] limite,
  output logic [3:0] jogada,
  output logic [3:0] memoria,
  output logic       fim_seq,
  output logic       tem_jogada
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_t;
  logic          botoes_prev;

  assign tem_jogada = |botoes;
  assign memoria    = rom_data(endereco);
  assign fim_seq    = (endereco == 4'hF);

  always_ff @(posedge clock) begin
    if (reset) begin
      endereco    <= '0;
      limite      <= '0;
      jogada      <= '0;
      cnt_t       <= '0;
      botoes_prev <= 1'b0;
    end else begin
      botoes_prev <= tem_jogada;
      if (fd.zera_e)        endereco <= '0;
      else if (fd.conta_e)  endereco <= endereco + 4'd1;
      if (fd.zera_l)        limite <= '0;
      else if (fd.conta_l)  limite <= limite + 4'd1;
      if (fd.zera_r)        jogada <= '0;
      else if (fd.registra) jogada <= botoes;
      // stops at its last count so the expiry flag stays stable
      if (fd.zera_t)                          cnt_t <= '0;
      else if (fd.conta_t && cnt_t != T_LAST) cnt_t <= cnt_t + 1'b1;
    end
  end

  assign st.jogada       = tem_jogada & ~botoes_prev;
  assign st.fim_timeout  = (cnt_t == T_LAST);
  assign st.igual_jogada = (jogada == memoria);
  assign st.igual_seq    = (endereco == limite);
  assign st.fim_rodadas  = (limite == 4'hF);
endmodule

// File: rtl/circuito_exp6_hexa7seg.sv
// Hex digit to 7-segment decoder, active-low, bit order gfedcba.
//  hexa  in  4  digit value
//  sseg  out 7  segment drive (0 = lit)
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] sseg
);
  always_comb begin
    sseg = 7'b1111111;
    case (hexa)
      4'h0: sseg = 7'b1000000;  4'h1: sseg = 7'b1111001;
      4'h2: sseg = 7'b0100100;  4'h3: sseg = 7'b0110000;
      4'h4: sseg = 7'b0011001;  4'h5: sseg = 7'b0010010;
      4'h6: sseg = 7'b0000010;  4'h7: sseg = 7'b1111000;
      4'h8: sseg = 7'b0000000;  4'h9: sseg = 7'b0010000;
      4'hA: sseg = 7'b0001000;  4'hB: sseg = 7'b0000011;
      4'hC: sseg = 7'b1000110;  4'hD: sseg = 7'b0100001;
      4'hE: sseg = 7'b0000110;  4'hF: sseg = 7'b0001110;
      default: sseg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/circuito_exp6_uc.sv
// Game controller (unidade de controle). Outputs are registered from the
// next-state decode so they line up exactly with the state they belong to.
//  clock, reset   sync active-high reset
//  jogar          start/restart request
//  st             datapath conditions
//  fd             datapath strobes
//  ganhou/perdeu/pronto/timeout  game flags
//  estado         current state code
module unidade_controle_exp6
  import circuito_exp6_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  status_t    st,
  output ctrl_fd_t   fd,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] estado
);
  estado_t estado_q, estado_d;
  saida_t  s_q;

  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:        estado_d = jogar ? PREPARA : INICIAL;
      PREPARA:        estado_d = INICIO_RODADA;
      INICIO_RODADA:  estado_d = ESPERA_JOGADA;
      // a button event wins over a timeout landing on the same cycle
      ESPERA_JOGADA:  estado_d = st.jogada      ? REGISTRA :
                                 st.fim_timeout ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA:       estado_d = COMPARA;
      COMPARA:        estado_d = !st.igual_jogada ? FIM_ERRO :
                                 !st.igual_seq    ? PROXIMA_JOGADA :
                                 st.fim_rodadas   ? FIM_GANHOU : PROXIMA_RODADA;
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIO_RODADA;
      FIM_GANHOU, FIM_ERRO, FIM_TIMEOUT:
                      estado_d = jogar ? PREPARA : estado_q;
      default:        estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      s_q      <= '0;
    end else begin
      estado_q <= estado_d;
      s_q      <= decodifica(estado_d);
    end
  end

  assign fd      = s_q.fd;
  assign ganhou  = s_q.ganhou;
  assign perdeu  = s_q.perdeu;
  assign pronto  = s_q.pronto;
  assign timeout = s_q.timeout;
  assign estado  = estado_q;
endmodule

// File: rtl/circuito_exp6.sv
// Memory game top: controller + datapath + four 7-segment debug decoders.
//  clock, reset (sync, active-high), jogar, botoes[3:0]
//  ganhou, perdeu, pronto, leds[3:0]
//  db_*: debug taps (7-seg digits, state code, comparator/event flags)
module circuito_exp6
  import circuito_exp6_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_sequencia,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_fimseq,
  output logic       db_igualseq,
  output logic       db_igualjogada,
  output logic       db_tem_jogada,
  output logic       db_timeout
);
  ctrl_fd_t   fd;
  status_t    st;
  logic [3:0] estado, endereco, limite, jogada, memoria;

  unidade_controle_exp6 u_uc (
    .clock(clock), .reset(reset), .jogar(jogar), .st(st), .fd(fd),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(db_timeout),
    .estado(estado)
  );

  fluxo_dados_exp6 #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fd (
    .clock(clock), .reset(reset), .fd(fd), .botoes(botoes), .st(st),
    .endereco(endereco), .limite(limite), .jogada(jogada), .memoria(memoria),
    .fim_seq(db_fimseq), .tem_jogada(db_tem_jogada)
  );

  hexa7seg u_hex_cont (.hexa(endereco), .sseg(db_contagem));
  hexa7seg u_hex_mem  (.hexa(memoria),  .sseg(db_memoria));
  hexa7seg u_hex_jog  (.hexa(jogada),   .sseg(db_jogadafeita));
  hexa7seg u_hex_seq  (.hexa(limite),   .sseg(db_sequencia));

  assign leds           = jogada;
  assign db_estado      = {3'b000, estado};
  assign db_igualjogada = st.igual_jogada;
  assign db_igual       = st.igual_jogada;
  assign db_igualseq    = st.igual_seq;
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
endmodule

// File: tb/tb_circuito_exp6.sv
module tb_circuito_exp6;
  localparam int T = 3000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       ganhou, perdeu, pronto;
  logic [3:0] leds;
  logic       db_igual, db_clock, db_iniciar, db_fimseq, db_igualseq;
  logic       db_igualjogada, db_tem_jogada, db_timeout;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;

  int checks = 0;
  int failures = 0;

  logic [3:0] rom_tb [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                              4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                              4'b1000, 4'b1000, 4'b0001, 4'b0100};

  circuito_exp6 #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
    .db_sequencia(db_sequencia), .db_clock(db_clock), .db_iniciar(db_iniciar),
    .db_fimseq(db_fimseq), .db_igualseq(db_igualseq),
    .db_igualjogada(db_igualjogada), .db_tem_jogada(db_tem_jogada),
    .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    botoes = b;
    step(10);
    botoes = 4'b0000;
    step(10);
  endtask

  task automatic start_game();
    jogar = 1'b1;
    step(3);
    jogar = 1'b0;
    chk("start_estado", {1'b0, db_estado}, 8'h02);
  endtask

  typedef struct {
    logic       jogar;
    logic [3:0] botoes;
    int         ciclos;
    logic [3:0] estado;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu;
    logic [3:0] cont, seq;
  } vec_t;

  vec_t vecs [11];

  initial begin
    //        jogar botoes  cyc est   leds   p  g  l  cont  seq
    vecs[0]  = '{1'b0, 4'h0, 20, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 4'h0,  2, 4'h9, 4'h0, 0, 0, 0, 4'h0, 4'h0};
    vecs[2]  = '{1'b1, 4'h0,  1, 4'h2, 4'h0, 0, 0, 0, 4'h0, 4'h0};
    vecs[3]  = '{1'b1, 4'h0,  2, 4'h2, 4'h0, 0, 0, 0, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 4'h0,  5, 4'h2, 4'h0, 0, 0, 0, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 4'h1,  1, 4'h3, 4'h0, 0, 0, 0, 4'h0, 4'h0};
    vecs[6]  = '{1'b0, 4'h1,  1, 4'h4, 4'h1, 0, 0, 0, 4'h0, 4'h0};
    vecs[7]  = '{1'b0, 4'h1,  1, 4'h6, 4'h1, 0, 0, 0, 4'h0, 4'h0};
    vecs[8]  = '{1'b0, 4'h1,  1, 4'h9, 4'h1, 0, 0, 0, 4'h0, 4'h1};
    vecs[9]  = '{1'b0, 4'h1,  6, 4'h2, 4'h1, 0, 0, 0, 4'h0, 4'h1};
    vecs[10] = '{1'b0, 4'h0, 10, 4'h2, 4'h1, 0, 0, 0, 4'h0, 4'h1};

    // reset state
    step(1);
    reset = 1'b0;
    chk("rst_estado", {1'b0, db_estado}, 8'h00);
    chk("rst_pronto", {7'b0, pronto}, 8'h00);
    chk("rst_ganhou", {7'b0, ganhou}, 8'h00);
    chk("rst_perdeu", {7'b0, perdeu}, 8'h00);
    chk("rst_leds", {4'b0, leds}, 8'h00);

    // idle, start, round 0
    for (int i = 0; i < 11; i++) begin
      jogar  = vecs[i].jogar;
      botoes = vecs[i].botoes;
      step(vecs[i].ciclos);
      chk($sformatf("v%0d_estado", i), {1'b0, db_estado}, {4'b0, vecs[i].estado});
      chk($sformatf("v%0d_leds", i), {4'b0, leds}, {4'b0, vecs[i].leds});
      chk($sformatf("v%0d_pronto", i), {7'b0, pronto}, {7'b0, vecs[i].pronto});
      chk($sformatf("v%0d_ganhou", i), {7'b0, ganhou}, {7'b0, vecs[i].ganhou});
      chk($sformatf("v%0d_perdeu", i), {7'b0, perdeu}, {7'b0, vecs[i].perdeu});
      chk($sformatf("v%0d_cont", i), {1'b0, db_contagem}, {1'b0, seg(vecs[i].cont)});
      chk($sformatf("v%0d_seq", i), {1'b0, db_sequencia}, {1'b0, seg(vecs[i].seq)});
      chk($sformatf("v%0d_iniciar", i), {7'b0, db_iniciar}, {7'b0, vecs[i].jogar});
    end

    // rest of the game: rounds 1..15
    for (int r = 1; r < 16; r++) begin
      for (int k = 0; k <= r; k++) press(rom_tb[k]);
      if (r < 15) begin
        chk($sformatf("r%0d_estado", r), {1'b0, db_estado}, 8'h02);
        chk($sformatf("r%0d_seq", r), {1'b0, db_sequencia}, {1'b0, seg(4'(r + 1))});
      end
    end
    chk("win_estado", {1'b0, db_estado}, 8'h0A);
    chk("win_ganhou", {7'b0, ganhou}, 8'h01);
    chk("win_pronto", {7'b0, pronto}, 8'h01);
    chk("win_perdeu", {7'b0, perdeu}, 8'h00);
    chk("win_fimseq", {7'b0, db_fimseq}, 8'h01);
    chk("win_igualseq", {7'b0, db_igualseq}, 8'h01);
    chk("win_leds", {4'b0, leds}, 8'h04);
    chk("win_mem", {1'b0, db_memoria}, {1'b0, seg(4'h4)});

    // wrong jogada at round 2, address 2
    start_game();
    press(4'b0001);
    press(4'b0001); press(4'b0010);
    press(4'b0001); press(4'b0010); press(4'b1000);
    chk("err_estado", {1'b0, db_estado}, 8'h0E);
    chk("err_perdeu", {7'b0, perdeu}, 8'h01);
    chk("err_pronto", {7'b0, pronto}, 8'h01);
    chk("err_ganhou", {7'b0, ganhou}, 8'h00);
    chk("err_leds", {4'b0, leds}, 8'h08);
    chk("err_igual", {7'b0, db_igual}, 8'h00);
    chk("err_cont", {1'b0, db_contagem}, {1'b0, seg(4'h2)});
    chk("err_jogadafeita", {1'b0, db_jogadafeita}, {1'b0, seg(4'h8)});

    // timeout: exactly T cycles in ESPERA_JOGADA
    start_game();
    step(T - 1);
    chk("to_pre_estado", {1'b0, db_estado}, 8'h02);
    chk("to_pre_timeout", {7'b0, db_timeout}, 8'h00);
    step(1);
    chk("to_estado", {1'b0, db_estado}, 8'h0D);
    chk("to_timeout", {7'b0, db_timeout}, 8'h01);
    chk("to_perdeu", {7'b0, perdeu}, 8'h01);
    chk("to_pronto", {7'b0, pronto}, 8'h01);

    // held button gives a single registration
    start_game();
    botoes = 4'b0001;
    step(50);
    chk("hold_tem_jogada", {7'b0, db_tem_jogada}, 8'h01);
    chk("hold_estado", {1'b0, db_estado}, 8'h02);
    chk("hold_cont", {1'b0, db_contagem}, {1'b0, seg(4'h0)});
    chk("hold_seq", {1'b0, db_sequencia}, {1'b0, seg(4'h1)});
    botoes = 4'b0000;
    step(10);
    press(4'b0001);
    chk("hold_next_cont", {1'b0, db_contagem}, {1'b0, seg(4'h1)});
    chk("hold_next_estado", {1'b0, db_estado}, 8'h02);

    // reset mid-round
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mrst_estado", {1'b0, db_estado}, 8'h00);
    chk("mrst_leds", {4'b0, leds}, 8'h00);
    chk("mrst_cont", {1'b0, db_contagem}, {1'b0, seg(4'h0)});
    chk("mrst_seq", {1'b0, db_sequencia}, {1'b0, seg(4'h0)});
    step(5);
    chk("mrst_idle_estado", {1'b0, db_estado}, 8'h00);
    chk("mrst_pronto", {7'b0, pronto}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
